// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer: 1 s prescaler, per-phase countdown, pedestrian latch/serve, lamp decode.
// Optional build macro SIDE_SENSOR_EN adds the side_car input and lets MAIN green rest until demand appears.
module intersection_phase_scheduler #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned MAIN_GREEN = 15,
  parameter int unsigned SIDE_GREEN = 10,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 1,
  parameter int unsigned MIN_GREEN  = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
`ifdef SIDE_SENSOR_EN
  input  logic             side_car,
`endif
  output logic             main_r,
  output logic             main_y,
  output logic             main_g,
  output logic             side_r,
  output logic             side_y,
  output logic             side_g,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase,
  output logic             tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR2   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pending_q, pending_d;
  logic               served_q, served_d;
  logic               ack_q, ack_d;
  logic               tick_w;
  logic               may_advance;
  logic               enter_side;

  function automatic state_e next_of(input state_e s);
    case (s)
      MAIN_G:  next_of = MAIN_Y;
      MAIN_Y:  next_of = CLR1;
      CLR1:    next_of = SIDE_G;
      SIDE_G:  next_of = SIDE_Y;
      SIDE_Y:  next_of = CLR2;
      default: next_of = MAIN_G;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input state_e s);
    case (s)
      MAIN_Y, SIDE_Y: dur_of = CNT_W'(YELLOW_T);
      CLR1, CLR2:     dur_of = CNT_W'(ALLRED_T);
      SIDE_G:         dur_of = CNT_W'(SIDE_GREEN);
      default:        dur_of = CNT_W'(MAIN_GREEN);
    endcase
  endfunction

  assign tick_w = (div_q == DIV_W'(TICK_DIV - 1));

`ifdef SIDE_SENSOR_EN
  // MAIN green may only give way when someone is actually waiting on the side road.
  assign may_advance = (state_q != MAIN_G) || side_car || pending_q;
`else
  assign may_advance = 1'b1;
`endif

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MAIN_G;
      cnt_q     <= CNT_W'(MAIN_GREEN);
      div_q     <= '0;
      pending_q <= 1'b0;
      served_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      served_q  <= served_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    served_d   = served_q;
    ack_d      = 1'b0;
    enter_side = 1'b0;
    div_d      = tick_w ? '0 : div_q + 1'b1;
    if (state_q > CLR2) begin
      state_d  = MAIN_G;
      cnt_d    = CNT_W'(MAIN_GREEN);
      served_d = 1'b0;
    end else if (tick_w) begin
      if (cnt_q == CNT_W'(1) && may_advance) begin
        state_d  = next_of(state_q);
        cnt_d    = dur_of(state_d);
        served_d = 1'b0;
        if (state_d == SIDE_G) begin
          enter_side = 1'b1;
          served_d   = pending_q;
          ack_d      = pending_q;
        end
      end else if (state_q == MAIN_G && pending_q && cnt_q > CNT_W'(MIN_GREEN)) begin
        cnt_d = CNT_W'(MIN_GREEN);
      end else if (cnt_q != CNT_W'(1)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    // A new press in the serving cycle survives so it is served on the next round.
    pending_d = ped_req || (pending_q && !enter_side);
  end

  always_comb begin
    main_r = 1'b1;
    main_y = 1'b0;
    main_g = 1'b0;
    side_r = 1'b1;
    side_y = 1'b0;
    side_g = 1'b0;
    case (state_q)
      MAIN_G: begin main_g = 1'b1; main_r = 1'b0; end
      MAIN_Y: begin main_y = 1'b1; main_r = 1'b0; end
      SIDE_G: begin side_g = 1'b1; side_r = 1'b0; end
      SIDE_Y: begin side_y = 1'b1; side_r = 1'b0; end
      default: ;
    endcase
    walk      = (state_q == SIDE_G) && served_q;
    ped_ack   = ack_q;
    countdown = cnt_q;
    phase     = state_q;
    tick      = tick_w;
  end

endmodule
